// File: rtl/snoopy_bus_arbiter_pkg.sv
// Shared types for the snoopy coherence bus arbiter.
package snoopy_bus_arbiter_pkg;

  // IDLE    : no owner, arbitrating on the sampled requests
  // GRANTED : one cache owns the bus until it drops its request
  // RELEASE : one turnaround cycle so the bus mux and shared-line OR settle
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } BusArbiterState;

endpackage

// File: rtl/snoopy_bus_arbiter_round_robin_picker.sv
// Combinational wrap-around priority search. The device after the last owner
// has highest priority and the last owner itself has lowest. Kept free of any
// state so the snoop-response path can reuse it.
module snoopy_bus_arbiter_round_robin_picker #(
  parameter int  NUMBER_OF_DEVICES = 4,
  localparam int INDEX_WIDTH       = $clog2(NUMBER_OF_DEVICES)
) (
  input  logic [NUMBER_OF_DEVICES-1:0] requests_i,
  input  logic [INDEX_WIDTH-1:0]       last_owner_i,
  output logic [INDEX_WIDTH-1:0]       winner_o,
  output logic                         valid_o
);

  // Walk offsets from farthest to nearest so the nearest set bit overwrites.
  always_comb begin
    int                     cand;
    logic [INDEX_WIDTH-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int off = NUMBER_OF_DEVICES; off >= 1; off--) begin
      cand     = (int'(last_owner_i) + off) % NUMBER_OF_DEVICES;
      cand_idx = INDEX_WIDTH'(cand);
      if (requests_i[cand_idx]) begin
        winner_o = cand_idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin owner arbitration for the shared snoopy coherence bus.
// A grant is held for the whole transaction (no preemption), followed by a
// fixed turnaround cycle. A sticky watchdog flags owners holding too long.
module snoopy_bus_arbiter
  import snoopy_bus_arbiter_pkg::*;
#(
  parameter int  NUMBER_OF_DEVICES = 4,
  parameter int  MAX_HOLD_CYCLES   = 64,
  localparam int INDEX_WIDTH       = $clog2(NUMBER_OF_DEVICES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMBER_OF_DEVICES-1:0] requests,
  output logic [NUMBER_OF_DEVICES-1:0] grants,
  output logic                         busBusy,
  output logic [INDEX_WIDTH-1:0]       owner,
  output logic                         holdTimeout
);

  localparam int HOLD_WIDTH = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_SAT    = HOLD_WIDTH'(MAX_HOLD_CYCLES);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_FIRE   = HOLD_WIDTH'(MAX_HOLD_CYCLES - 1);
  localparam logic [INDEX_WIDTH-1:0] OWNER_RESET = INDEX_WIDTH'(NUMBER_OF_DEVICES - 1);

  BusArbiterState                 state_q, state_d;
  logic [NUMBER_OF_DEVICES-1:0]   grants_q, grants_d;
  logic [INDEX_WIDTH-1:0]         owner_q, owner_d;
  logic [HOLD_WIDTH-1:0]          hold_q, hold_d;
  logic                           timeout_q, timeout_d;
  logic                           busy_q, busy_d;

  logic [INDEX_WIDTH-1:0]         pick_winner;
  logic                           pick_valid;

  snoopy_bus_arbiter_round_robin_picker #(
    .NUMBER_OF_DEVICES(NUMBER_OF_DEVICES)
  ) u_picker (
    .requests_i  (requests),
    .last_owner_i(owner_q),
    .winner_o    (pick_winner),
    .valid_o     (pick_valid)
  );

  // Next-state, grant, hold counter and watchdog decisions.
  always_comb begin
    state_d   = state_q;
    grants_d  = grants_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = GRANTED;
          grants_d = NUMBER_OF_DEVICES'(1) << pick_winner;
          owner_d  = pick_winner;
          hold_d   = '0;
        end
      end
      GRANTED: begin
        if (requests[owner_q]) begin
          if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_FIRE) timeout_d = 1'b1;
        end else begin
          state_d  = RELEASE;
          grants_d = '0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        grants_d = '0;
      end
    endcase
    // Busy is registered from the next state so it lines up with the state.
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grants_q  <= '0;
      owner_q   <= OWNER_RESET;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grants_q  <= grants_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign grants      = grants_q;
  assign busBusy     = busy_q;
  assign owner       = owner_q;
  assign holdTimeout = timeout_q;

endmodule
